// File: rtl/recog_pkg.sv
// rtl/recog_pkg.sv - shared types, widths and frame sizing for the match event reporter
package recog_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_SHIFT = 2'd1,
    RPT_GAP   = 2'd2
  } rpt_state_t;

  localparam int CNT_W_DEF = 8;
  localparam int RUN_W_DEF = 4;

  // Frame is {count, maxrun, ovf}
  function automatic int frame_w(input int cnt_w, input int run_w);
    return cnt_w + run_w + 1;
  endfunction

endpackage

// File: rtl/match_event_reporter_if.sv
// rtl/match_event_reporter_if.sv - recogniser inputs and serial readout pins
interface match_event_reporter_if;
  logic MatchBit;
  logic MatchAll;
  logic ReadReq;
  logic SerOut;
  logic SerValid;
  logic Busy;

  modport master (output MatchBit, MatchAll, ReadReq, input SerOut, SerValid, Busy);
  modport slave  (input MatchBit, MatchAll, ReadReq, output SerOut, SerValid, Busy);
endinterface

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - parallel-load, MSB-first serialiser with bit counter
module serial_tx_shifter #(
  parameter int W = 13
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sreg;
  logic [CW-1:0] left;

  // done flags the cycle carrying the final bit
  assign done = ser_valid && (left == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sreg      <= '0;
      left      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else if (load) begin
      sreg      <= data << 1;
      left      <= CW'(W - 1);
      ser_out   <= data[W-1];
      ser_valid <= 1'b1;
    end else if (ser_valid) begin
      if (done) begin
        ser_valid <= 1'b0;
        ser_out   <= 1'b0;
      end else begin
        ser_out <= sreg[W-1];
        sreg    <= sreg << 1;
        left    <= left - 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_event_reporter.sv
// rtl/match_event_reporter.sv - window statistics over recogniser matches, read out serially
module match_event_reporter
  import recog_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input logic                   Clock,
  input logic                   Reset,
  match_event_reporter_if.slave bus
);

  localparam int FRAME_W = frame_w(CNT_W, RUN_W);

  localparam logic [1:0] S_IDLE  = RPT_IDLE;
  localparam logic [1:0] S_SHIFT = RPT_SHIFT;
  localparam logic [1:0] S_GAP   = RPT_GAP;

  logic [1:0]       state;
  logic             busy_q;
  logic [CNT_W-1:0] count;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] maxrun;
  logic [RUN_W-1:0] run_next;
  logic [RUN_W-1:0] maxrun_next;
  logic             ovf;
  logic             accept;
  logic             shift_done;

  assign accept  = (state == S_IDLE) && bus.ReadReq;
  assign bus.Busy = busy_q;

  always_comb begin
    run_next = '0;
    if (bus.MatchBit) begin
      run_next = (&run) ? run : run + 1'b1;
    end
    maxrun_next = (run_next > maxrun) ? run_next : maxrun;
  end

  // On accept the old window is snapshotted; this edge's events start the new one
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count  <= '0;
      run    <= '0;
      maxrun <= '0;
      ovf    <= 1'b0;
    end else begin
      run <= run_next;
      if (accept) begin
        count  <= {{(CNT_W-1){1'b0}}, bus.MatchAll};
        maxrun <= run_next;
        ovf    <= 1'b0;
      end else begin
        maxrun <= maxrun_next;
        if (bus.MatchAll) begin
          if (&count) ovf <= 1'b1;
          else        count <= count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state  <= S_SHIFT;
          busy_q <= 1'b1;
        end
        S_SHIFT: if (shift_done) state <= S_GAP;
        S_GAP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  serial_tx_shifter #(.W(FRAME_W)) u_shifter (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (accept),
    .data      ({count, maxrun, ovf}),
    .ser_out   (bus.SerOut),
    .ser_valid (bus.SerValid),
    .done      (shift_done)
  );

endmodule
